// File: rtl/multi_alarm_clock_if.sv
// multi_alarm_clock_if: control and status bundle of the multi-alarm clock
// master drives the buttons/keypad/enables and observes time and alarm status;
// slave is the clock core.
interface multi_alarm_clock_if #(
    parameter int NUM_ALARMS = 4
);
    localparam int AW = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1;

    logic                  fastwatch;
    logic                  time_button;
    logic                  alarm_button;
    logic [AW-1:0]         alarm_sel;
    logic [3:0]            key;
    logic                  key_valid;
    logic [NUM_ALARMS-1:0] alarm_enable;
    logic                  stop_button;
    logic                  snooze_button;
    logic [4:0]            cur_hour;
    logic [5:0]            cur_min;
    logic [5:0]            cur_sec;
    logic [1:0]            mode;
    logic                  entry_error;
    logic [NUM_ALARMS-1:0] alarm_active;
    logic                  sound_alarm;

    modport master (
        output fastwatch, time_button, alarm_button, alarm_sel, key, key_valid,
               alarm_enable, stop_button, snooze_button,
        input  cur_hour, cur_min, cur_sec, mode, entry_error, alarm_active, sound_alarm
    );

    modport slave (
        input  fastwatch, time_button, alarm_button, alarm_sel, key, key_valid,
               alarm_enable, stop_button, snooze_button,
        output cur_hour, cur_min, cur_sec, mode, entry_error, alarm_active, sound_alarm
    );
endinterface

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: 24-hour clock with keypad time/alarm entry, NUM_ALARMS alarms and a 60 s ring timer
// Ports: clock (rising edge), reset_n (asynchronous, active-low),
//   bus (multi_alarm_clock_if.slave)
//   inputs:  fastwatch, time_button, alarm_button, alarm_sel, key, key_valid,
//            alarm_enable, stop_button, snooze_button
//   outputs: cur_hour, cur_min, cur_sec, mode, entry_error, alarm_active, sound_alarm
// Optional feature: define SNOOZE_EN to build the snooze logic; without it
// snooze_button is ignored.
module multi_alarm_clock #(
    parameter int NUM_ALARMS    = 4,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int SNOOZE_MIN    = 5
) (
    input logic                clock,
    input logic                reset_n,
    multi_alarm_clock_if.slave bus
);
    localparam int AW = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1;
    localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [1:0] NORMAL    = 2'b00;
    localparam logic [1:0] SET_TIME  = 2'b01;
    localparam logic [1:0] SET_ALARM = 2'b10;
    localparam logic [1:0] COMMIT    = 2'b11;

    logic [PW-1:0]         presc_q, presc_d;
    logic [4:0]            hour_q, hour_d;
    logic [5:0]            min_q, min_d, sec_q, sec_d;
    logic [1:0]            mode_q, mode_d;
    logic [15:0]           digits_q, digits_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [AW-1:0]         sel_q, sel_d;
    logic                  tgt_q, tgt_d;
    logic [4:0]            alarm_h_q [NUM_ALARMS];
    logic [4:0]            alarm_h_d [NUM_ALARMS];
    logic [5:0]            alarm_m_q [NUM_ALARMS];
    logic [5:0]            alarm_m_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] active_q, active_d, trig, restore;
    logic [5:0]            ring_q, ring_d;
    logic                  tick_q, tick_d;
    logic                  sec_tick, presc_wrap, entry_ok, time_load, alarm_load;
    logic                  expire, snooze_go, reassert;
    logic [6:0]            hh, mm;

    assign presc_wrap = presc_q == PW'(TICKS_PER_SEC - 1);
    assign sec_tick   = presc_wrap || bus.fastwatch;
    // Buffer holds H H M M as BCD digits, oldest in the top nibble.
    assign hh         = 7'(digits_q[15:12]) * 7'd10 + 7'(digits_q[11:8]);
    assign mm         = 7'(digits_q[7:4]) * 7'd10 + 7'(digits_q[3:0]);
    assign entry_ok   = hh <= 7'd23 && mm <= 7'd59 && (!tgt_q || 32'(sel_q) < NUM_ALARMS);
    assign time_load  = mode_q == COMMIT && entry_ok && !tgt_q;
    assign alarm_load = mode_q == COMMIT && entry_ok && tgt_q;

    assign bus.cur_hour     = hour_q;
    assign bus.cur_min      = min_q;
    assign bus.cur_sec      = sec_q;
    assign bus.mode         = mode_q;
    assign bus.entry_error  = mode_q == COMMIT && !entry_ok;
    assign bus.alarm_active = active_q;
    assign bus.sound_alarm  = |active_q;

    always_comb begin
        presc_d = (time_load || presc_wrap) ? '0 : presc_q + PW'(1);
        sec_d   = time_load ? 6'd0 : !sec_tick ? sec_q : sec_q == 6'd59 ? 6'd0 : sec_q + 6'd1;
        min_d   = time_load ? mm[5:0] : !(sec_tick && sec_q == 6'd59) ? min_q :
                  min_q == 6'd59 ? 6'd0 : min_q + 6'd1;
        hour_d  = time_load ? hh[4:0] : !(sec_tick && sec_q == 6'd59 && min_q == 6'd59) ? hour_q :
                  hour_q == 5'd23 ? 5'd0 : hour_q + 5'd1;
        // Only a real second step may arm the alarm compare; a load never does.
        tick_d  = sec_tick && !time_load;
    end

    always_comb begin
        mode_d   = mode_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        tgt_d    = tgt_q;
        if (mode_q == NORMAL) begin
            if (bus.time_button || bus.alarm_button) begin
                mode_d = bus.time_button ? SET_TIME : SET_ALARM;
                tgt_d  = !bus.time_button;
                cnt_d  = 2'd0;
                sel_d  = bus.alarm_sel;
            end
        end else if (mode_q == COMMIT) begin
            mode_d = NORMAL;
        end else if (bus.time_button || bus.alarm_button) begin
            mode_d = NORMAL;
        end else if (bus.key_valid && bus.key <= 4'd9) begin
            digits_d = {digits_q[11:0], bus.key};
            cnt_d    = cnt_q + 2'd1;
            mode_d   = cnt_q == 2'd3 ? COMMIT : mode_q;
        end
    end

    always_comb begin
        alarm_h_d = alarm_h_q;
        alarm_m_d = alarm_m_q;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (alarm_load && sel_q == AW'(i)) begin
                alarm_h_d[i] = hh[4:0];
                alarm_m_d[i] = mm[5:0];
            end
            trig[i] = tick_q && sec_q == 6'd0 && hour_q == alarm_h_q[i] &&
                      min_q == alarm_m_q[i] && bus.alarm_enable[i];
        end
    end

`ifdef SNOOZE_EN
    localparam int SNZ_T = SNOOZE_MIN * 60;
    logic                  snz_pend_q, snz_pend_d;
    logic [NUM_ALARMS-1:0] snz_bits_q, snz_bits_d;
    logic [11:0]           snz_cnt_q, snz_cnt_d;

    assign snooze_go = bus.snooze_button && |active_q;
    assign reassert  = snz_pend_q && sec_tick && snz_cnt_q == 12'(SNZ_T - 1) && !snooze_go;
    assign restore   = reassert ? snz_bits_q : '0;

    always_comb begin
        snz_pend_d = bus.stop_button ? 1'b0 : snooze_go ? 1'b1 : reassert ? 1'b0 : snz_pend_q;
        snz_bits_d = snooze_go ? active_q : snz_bits_q;
        snz_cnt_d  = snooze_go ? 12'd0 : (snz_pend_q && sec_tick) ? snz_cnt_q + 12'd1 : snz_cnt_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snz_pend_q <= 1'b0;
            snz_bits_q <= '0;
            snz_cnt_q  <= '0;
        end else begin
            snz_pend_q <= snz_pend_d;
            snz_bits_q <= snz_bits_d;
            snz_cnt_q  <= snz_cnt_d;
        end
    end
`else
    logic unused_snooze;
    assign unused_snooze = bus.snooze_button;
    assign snooze_go     = 1'b0;
    assign reassert      = 1'b0;
    assign restore       = '0;
`endif

    // Ring timer counts sec_ticks while anything rings; the 60th tick silences all.
    assign expire = |active_q && sec_tick && ring_q == 6'd59;

    always_comb begin
        active_d = bus.stop_button ? '0 :
                   (((expire || snooze_go) ? '0 : active_q) | trig | restore) & bus.alarm_enable;
        ring_d   = (|trig || reassert) ? 6'd0 : (|active_q && sec_tick) ? ring_q + 6'd1 : ring_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q  <= '0;
            hour_q   <= '0;
            min_q    <= '0;
            sec_q    <= '0;
            mode_q   <= NORMAL;
            digits_q <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            tgt_q    <= 1'b0;
            active_q <= '0;
            ring_q   <= '0;
            tick_q   <= 1'b0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alarm_h_q[i] <= '0;
                alarm_m_q[i] <= '0;
            end
        end else begin
            presc_q   <= presc_d;
            hour_q    <= hour_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            mode_q    <= mode_d;
            digits_q  <= digits_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            tgt_q     <= tgt_d;
            active_q  <= active_d;
            ring_q    <= ring_d;
            tick_q    <= tick_d;
            alarm_h_q <= alarm_h_d;
            alarm_m_q <= alarm_m_d;
        end
    end
endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb_multi_alarm_clock: scoreboard bench for multi_alarm_clock against a seconds-of-day reference model
module tb_multi_alarm_clock;
    localparam int NA  = 3;
    localparam int TPS = 4;
    localparam int SM  = 2;

    typedef struct {
        int          h, m, s, md;
        bit          err;
        bit [NA-1:0] act;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    multi_alarm_clock_if #(.NUM_ALARMS(NA)) bus_if ();
    multi_alarm_clock #(.NUM_ALARMS(NA), .TICKS_PER_SEC(TPS), .SNOOZE_MIN(SM)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus_if)
    );

    always #5 clock = ~clock;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    bit          rst_s = 1'b0, fw_s = 1'b0;
    bit [NA-1:0] en_s = '0;
    bit [1:0]    sel_s = '0;

    int          pre, tod, md, sel, rl, sc;
    int          dg[$];
    int          al[NA];
    bit          tgt, ptick, sp;
    bit [NA-1:0] act, sb;

    function automatic bit entry_good();
        int hh = dg[0] * 10 + dg[1];
        int mm = dg[2] * 10 + dg[3];
        return hh <= 23 && mm <= 59 && (!tgt || sel < NA);
    endfunction

    task automatic model_step();
        exp_t        e;
        bit          tick, ok, reas;
        int          hh, mm;
        bit [NA-1:0] trig, nxt;
        if (!reset_n) begin
            pre = 0; tod = 0; md = 0; sel = 0; rl = 0; sc = 0;
            dg.delete();
            for (int i = 0; i < NA; i++) al[i] = 0;
            tgt = 0; ptick = 0; sp = 0; act = '0; sb = '0;
        end else begin
            tick = (pre == TPS - 1) || bus_if.fastwatch;
            ok = 0; hh = 0; mm = 0;
            if (md == 3) begin
                hh = dg[0] * 10 + dg[1];
                mm = dg[2] * 10 + dg[3];
                ok = entry_good();
            end
            for (int i = 0; i < NA; i++)
                trig[i] = ptick && (tod % 60 == 0) && (al[i] == tod / 60) && bus_if.alarm_enable[i];
            nxt  = act;
            reas = 0;
            if (act != 0 && tick) begin
                rl--;
                if (rl == 0) nxt = '0;
            end
`ifdef SNOOZE_EN
            if (bus_if.snooze_button && act != 0) begin
                sb = act; sp = 1; sc = SM * 60; nxt = '0;
            end else if (sp && tick) begin
                sc--;
                if (sc == 0) begin reas = 1; sp = 0; end
            end
`endif
            nxt |= trig;
            if (reas) nxt |= sb;
            if (trig != 0 || reas) rl = 60;
            if (bus_if.stop_button) begin nxt = '0; sp = 0; end
            act = nxt & bus_if.alarm_enable;
            if (md == 3 && ok && !tgt) begin
                tod = hh * 3600 + mm * 60; pre = 0; ptick = 0;
            end else begin
                pre = (pre + 1) % TPS;
                if (tick) tod = (tod + 1) % 86400;
                ptick = tick;
            end
            if (md == 3 && ok && tgt) al[sel] = hh * 60 + mm;
            case (md)
                0: begin
                    if (bus_if.time_button || bus_if.alarm_button) begin
                        md  = bus_if.time_button ? 1 : 2;
                        tgt = !bus_if.time_button;
                        sel = int'(bus_if.alarm_sel);
                        dg.delete();
                    end
                end
                3: md = 0;
                default: begin
                    if (bus_if.time_button || bus_if.alarm_button) md = 0;
                    else if (bus_if.key_valid && bus_if.key <= 4'd9) begin
                        dg.push_back(int'(bus_if.key));
                        if (dg.size() == 4) md = 3;
                    end
                end
            endcase
        end
        e.h   = tod / 3600;
        e.m   = (tod / 60) % 60;
        e.s   = tod % 60;
        e.md  = md;
        e.act = act;
        e.err = (md == 3) ? !entry_good() : 1'b0;
        q.push_back(e);
    endtask

    task automatic cyc(input bit tbn, input bit abn, input bit kv, input int k, input bit st, input bit sn);
        @(negedge clock);
        reset_n              = rst_s;
        bus_if.fastwatch     = fw_s;
        bus_if.alarm_enable  = en_s;
        bus_if.alarm_sel     = sel_s;
        bus_if.time_button   = tbn;
        bus_if.alarm_button  = abn;
        bus_if.key_valid     = kv;
        bus_if.key           = 4'(k);
        bus_if.stop_button   = st;
        bus_if.snooze_button = sn;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic enter(input bit alarm, input int d0, input int d1, input int d2, input int d3);
        cyc(!alarm, alarm, 0, 0, 0, 0);
        cyc(0, 0, 1, d0, 0, 0);
        cyc(0, 0, 1, 13, 0, 0);
        cyc(0, 0, 1, d1, 0, 0);
        cyc(0, 0, 1, d2, 0, 0);
        cyc(0, 0, 1, d3, 0, 0);
        idle(2);
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("cur_hour", int'(bus_if.cur_hour), e.h);
                chk("cur_min", int'(bus_if.cur_min), e.m);
                chk("cur_sec", int'(bus_if.cur_sec), e.s);
                chk("mode", int'(bus_if.mode), e.md);
                chk("entry_error", int'(bus_if.entry_error), int'(e.err));
                chk("alarm_active", int'(bus_if.alarm_active), int'(e.act));
                chk("sound_alarm", int'(bus_if.sound_alarm), int'(|e.act));
            end
        end
    end

    initial begin
        bus_if.fastwatch = 0; bus_if.time_button = 0; bus_if.alarm_button = 0;
        bus_if.alarm_sel = 0; bus_if.key = 0; bus_if.key_valid = 0;
        bus_if.alarm_enable = 0; bus_if.stop_button = 0; bus_if.snooze_button = 0;
        idle(3);
        rst_s = 1;
        idle(20);
        en_s = 3'b001;
        enter(0, 2, 3, 5, 9);
        fw_s = 1;
        idle(64);
        cyc(0, 0, 0, 0, 1, 0);
        fw_s = 0;
        enter(0, 1, 2, 3, 0);
        idle(5);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 2, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(3);
        en_s = 3'b000;
        sel_s = 2; enter(1, 2, 4, 0, 0);
        sel_s = 3; enter(1, 0, 7, 0, 0);
        sel_s = 1; enter(1, 0, 7, 0, 0);
        en_s = 3'b010; fw_s = 1;
        enter(0, 0, 6, 5, 9);
        idle(66);
        cyc(0, 0, 0, 0, 1, 0);
        idle(3);
        enter(0, 0, 6, 5, 9);
        idle(135);
        enter(0, 0, 6, 5, 9);
        idle(66);
        cyc(0, 0, 0, 0, 0, 1);
        idle(SM * 60 + 10);
        cyc(0, 0, 0, 0, 1, 0);
        enter(0, 0, 6, 5, 9);
        idle(66);
        cyc(0, 0, 0, 0, 1, 1);
        idle(SM * 60 + 10);
        sel_s = 0; enter(1, 0, 8, 0, 0);
        sel_s = 2; enter(1, 0, 8, 0, 0);
        en_s = 3'b111;
        enter(0, 0, 7, 5, 9);
        idle(66);
        en_s = 3'b011;
        idle(5);
        cyc(0, 0, 0, 0, 1, 0);
        rst_s = 0;
        cyc(1, 0, 0, 0, 0, 0);
        rst_s = 1;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        rst_s = 0;
        idle(2);
        rst_s = 1;
        idle(4);
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(49) == 0) fw_s = ~fw_s;
            if ($urandom_range(99) == 0) en_s = NA'($urandom);
            sel_s = 2'($urandom);
            rst_s = $urandom_range(699) != 0;
            cyc($urandom_range(39) == 0, $urandom_range(39) == 0, $urandom_range(2) == 0,
                int'($urandom_range(15)), $urandom_range(99) == 0, $urandom_range(59) == 0);
        end
        rst_s = 1;
        idle(3);
        @(posedge clock);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock
Interface
REQ-001 SHALL have parameter NUM_ALARMS, default 4, number of independent alarm channels (1..8).
REQ-002 SHALL have parameter TICKS_PER_SEC, default 50_000_000, clock cycles per second.
REQ-003 SHALL have parameter SNOOZE_MIN, default 5, snooze delay in minutes (1..59).
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-005 clock  in  1  single rising-edge clock for all state.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 fastwatch  in  1  when 1, every clock cycle is one second.
REQ-008 time_button  in  1  level; enter time-set or abort entry.
REQ-009 alarm_button  in  1  level; enter alarm-set or abort entry.
REQ-010 alarm_sel  in  AW=max(1,clog2(NUM_ALARMS))  alarm index, sampled on entry to SET_ALARM.
REQ-011 key  in  4  BCD digit; values >9 ignored.
REQ-012 key_valid  in  1  one-cycle strobe qualifying key.
REQ-013 alarm_enable  in  NUM_ALARMS  per-alarm arm bits.
REQ-014 stop_button  in  1  silence all ringing alarms.
REQ-015 snooze_button  in  1  snooze ringing alarms.
REQ-016 cur_hour / cur_min / cur_sec  out  5/6/6  current time, binary.
REQ-017 mode  out  2  00 NORMAL, 01 SET_TIME, 10 SET_ALARM, 11 COMMIT.
REQ-018 entry_error  out  1  one-cycle pulse on rejected entry.
REQ-019 alarm_active  out  NUM_ALARMS  per-alarm ringing flags; sound_alarm  out  1  OR of alarm_active.
Function
REQ-020 Prescaler SHALL count 0..TICKS_PER_SEC-1 and wrap; sec_tick = (count==TICKS_PER_SEC-1) or fastwatch.
REQ-021 On sec_tick: sec 59->0 carries to min, min 59->0 carries to hour, hour 23->0; no other wrap.
REQ-022 Time SHALL keep running in every mode, including during entry.
REQ-023 FSM in NORMAL: time_button->SET_TIME (priority), else alarm_button->SET_ALARM; entry clears the digit counter and latches alarm_sel.
REQ-024 In SET_*: each key_valid with key<=9 shifts the digit into a 4-digit HHMM buffer; 4th digit->COMMIT next cycle.
REQ-025 In SET_*: time_button or alarm_button asserted ->NORMAL with no load.
REQ-026 COMMIT SHALL last one cycle: HH<=23 and MM<=59 loads; else entry_error=1 and no load; always ->NORMAL.
REQ-027 Time load SHALL set hour/min, zero sec and the prescaler; alarm load writes only slot latched alarm_sel (index >=NUM_ALARMS: reject with entry_error).
REQ-028 Alarm i SHALL trigger the cycle after a sec_tick updates time to alarm_i HH:MM:00 while alarm_enable[i]=1; a time load never triggers.
REQ-029 Trigger sets alarm_active[i] and restarts a shared 60 s ring timer; on expiry all alarm_active clear.
REQ-030 stop_button clears all alarm_active and any pending snooze next cycle; stop beats snooze and a same-cycle trigger.
REQ-031 alarm_enable[i]=0 SHALL clear alarm_active[i] next cycle.
REQ-032 Simultaneous triggers of several alarms SHALL set all matching bits in the same cycle.
Reset
REQ-033 reset_n=0 SHALL immediately force time 00:00:00, prescaler 0, mode NORMAL, all alarm slots 00:00, alarm_active 0, entry_error 0, snooze idle.
REQ-034 Reset mid-entry SHALL discard buffered digits; outputs SHALL be valid from the first edge after release.
Configuration
REQ-035 With SNOOZE_EN defined: snooze_button while sound_alarm=1 saves alarm_active, clears it, and reasserts the saved bits after SNOOZE_MIN*60 sec_ticks; a new snooze restarts the delay.
REQ-036 Without SNOOZE_EN: snooze_button SHALL be ignored and no snooze logic synthesised.
Verification
REQ-037 fastwatch=1, time 23:59:58 -> after 2 cycles 00:00:00.
REQ-038 time_button, keys 1,2,3,0 -> mode 11 one cycle, then time 12:30:00, mode 00.
REQ-039 alarm_sel=2, keys 2,4,0,0 -> entry_error pulse, alarm 2 unchanged.
REQ-040 alarm 1=07:00 enabled, time 06:59:59, fastwatch -> alarm_active=0010 one cycle after 07:00:00; stop_button -> 0000.
REQ-041 SNOOZE_EN, SNOOZE_MIN=5, alarm 0 ringing, snooze -> sound_alarm 0, reasserts after 300 sec_ticks.
REQ-042 Ringing, no stop -> alarm_active clears after 60 sec_ticks; stop+snooze same cycle -> no re-ring.
